// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver that produces the pong game's btn[3:0] paddle controls.
// The raw PS/2 clock and data lines are synchronised and the clock is filtered.
// 11-bit frames are deframed, and make/break/extended sequences become held key bits.
// Optional macro PS2_ERR_CLEAR_EN: when defined, every frame_err pulse also clears btn.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] btn,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

   // Receive FSM states. The FSM advances only on filtered falling edges of ps2_clk.
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_n;

   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic          filt_clk, filt_prev;
   logic [FW-1:0] filt_cnt;
   logic [TW-1:0] tout_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          ext, brk;
   logic          sample_edge, good_byte, err;

   // Two-flop synchronisers for both asynchronous inputs. They idle high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   // Glitch filter: the filtered clock flips only after FILTER_LEN consecutive samples at the new level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         filt_prev <= filt_clk;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_MAX) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // The 1->0 transition of the filtered clock is the bit sample point.
   assign sample_edge = filt_prev & ~filt_clk;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic, with good-byte and error strobes. A timeout overrides any mid-frame state.
   always_comb begin
      state_n   = state;
      good_byte = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: if (sample_edge) begin
            if (!data_s2) state_n = DATA;
            else          err     = 1'b1;
         end
         DATA:   if (sample_edge && bit_cnt == 3'd7) state_n = PARITY;
         PARITY: if (sample_edge) state_n = STOP;
         STOP: if (sample_edge) begin
            state_n = IDLE;
            if (data_s2 && (^{shreg, par_bit})) good_byte = 1'b1;
            else                                err       = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (state != IDLE && !sample_edge && tout_cnt == TOUT_MAX) begin
         state_n = IDLE;
         err     = 1'b1;
      end
   end

   // Frame datapath: shift register (LSB first), bit counter, parity latch and inactivity timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tout_cnt <= '0;
      end else begin
         if (state == IDLE || sample_edge) tout_cnt <= '0;
         else                              tout_cnt <= tout_cnt + 1'b1;
         if (sample_edge) begin
            case (state)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shreg   <= {data_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: par_bit <= data_s2;
               default: ;
            endcase
         end
      end
   end

   // Output stage: publish good bytes, decode prefixes/keys into btn, and report errors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn        <= '0;
         scan_code  <= '0;
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
         ext        <= 1'b0;
         brk        <= 1'b0;
      end else begin
         scan_valid <= good_byte;
         frame_err  <= err;
         if (err) begin
            ext <= 1'b0;
            brk <= 1'b0;
`ifdef PS2_ERR_CLEAR_EN
            btn <= '0;
`else
            btn <= btn;
`endif
         end else if (good_byte) begin
            scan_code <= shreg;
            if (shreg == 8'hE0) begin
               ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               case ({ext, shreg})
                  9'h01D: btn[0] <= ~brk;
                  9'h01B: btn[1] <= ~brk;
                  9'h175: btn[2] <= ~brk;
                  9'h172: btn[3] <= ~brk;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
